// File: rtl/tt_out_uart_logger.sv
// Change-capture logger: queues each new value of data_in seen while ena is high
// and streams the queued bytes out as UART 8N1 frames on tx.
`timescale 1ns/1ps
module tt_out_uart_logger #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count,
    output logic       overflow
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        DEPTH     = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t            r_state;
    logic [7:0]        r_prev;
    logic              r_prev_valid;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [4:0]        r_count;
    logic              r_overflow;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit;
    logic [BAUD_W-1:0] r_baud;
    logic              r_tx;

    logic w_push_req;
    logic w_pop;
    logic w_push;

    assign w_push_req = ena && (!r_prev_valid || (data_in != r_prev));
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push     = w_push_req && ((r_count < DEPTH) || w_pop);

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (ena) begin
                r_prev       <= data_in;
                r_prev_valid <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_bit   <= '0;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // tx is loaded with the next bit so it stays purely registered
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_tt_out_uart_logger.sv
// Directed bench for tt_out_uart_logger: a cycle table for reset/first-frame timing,
// then sequences checked against a UART frame decoder running on the negative edge.
`timescale 1ns/1ps
module tb_tt_out_uart_logger;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] data_in;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;
    logic       overflow;

    tt_out_uart_logger #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .data_in    (data_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int max_count, busy_cycles, tx_low_cycles;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q [$];
    int         rx_t [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
        if (busy) busy_cycles++;
        if (tx !== 1'b1) tx_low_cycles++;
    endtask

    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; data_in = 8'h00;
        step();
        rst = 1'b0;
        step();
        rx_q.delete();
        rx_t.delete();
        max_count = 0; busy_cycles = 0; tx_low_cycles = 0;
    endtask

    // UART decoder: collects 40 samples per frame, abandons the frame if rst is applied
    logic [39:0] m_s;
    logic        m_abort, m_busy, m_ok;
    logic [7:0]  m_b;
    int          m_t0, m_i;
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                m_t0 = cyc; m_s = '1; m_s[0] = tx; m_busy = busy; m_abort = rst; m_i = 1;
                while (m_i < 40 && !m_abort) begin
                    @(negedge clk);
                    m_s[m_i] = tx;
                    m_busy = m_busy & busy;
                    if (rst) m_abort = 1'b1;
                    m_i++;
                end
                if (!m_abort) begin
                    m_ok = (m_s[0] === 1'b0) && (m_s[36] === 1'b1);
                    for (int g = 0; g < 10; g++)
                        for (int j = 0; j < 4; j++)
                            if (m_s[4*g+j] !== m_s[4*g]) m_ok = 1'b0;
                    for (int g = 1; g <= 8; g++) m_b[g-1] = m_s[4*g];
                    check("frame_shape", {31'd0, m_ok}, 32'd1);
                    check("frame_busy", {31'd0, m_busy}, 32'd1);
                    rx_q.push_back(m_b);
                    rx_t.push_back(m_t0);
                end
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       ena;
        logic [7:0] d;
        logic       tx;
        logic       busy;
        logic [4:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tv [19];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int tp, cnt_bad;
        logic found;
        rst = 1'b1; ena = 1'b0; data_in = 8'h00;
        max_count = 0; busy_cycles = 0; tx_low_cycles = 0;

        // rst, ena, data_in -> tx, busy, fifo_count, overflow after the edge
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};
        tv[2]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 5'd0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 5'd1, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[5]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[7]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 5'd0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 5'd0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 5'd0, 1'b0};
        tv[11] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 5'd0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[13] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 5'd1, 1'b0};
        tv[14] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b0};
        tv[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};
        tv[16] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0};
        tv[17] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
        tv[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};

        for (int i = 0; i < 19; i++) begin
            rst = tv[i].rst; ena = tv[i].ena; data_in = tv[i].d;
            step();
            check($sformatf("vec%0d_tx", i), {31'd0, tx}, {31'd0, tv[i].tx});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tv[i].busy});
            check($sformatf("vec%0d_count", i), {27'd0, fifo_count}, {27'd0, tv[i].cnt});
            check($sformatf("vec%0d_ovf", i), {31'd0, overflow}, {31'd0, tv[i].ovf});
        end

        // Single held value: one frame, tx falls one edge after the push edge
        do_reset();
        ena = 1'b1; data_in = 8'hA5;
        step();
        tp = cyc;
        check("s1_push_count", {27'd0, fifo_count}, 32'd1);
        busy_cycles = 0;
        repeat (120) step();
        check("s1_frames", rx_q.size(), 32'd1);
        if (rx_q.size() >= 1) begin
            check("s1_byte", {24'd0, rx_q[0]}, 32'hA5);
            check("s1_latency", rx_t[0] - tp, 32'd1);
        end
        check("s1_busy_cycles", busy_cycles, 32'd40);
        check("s1_ovf", {31'd0, overflow}, 32'd0);

        // Three values, then ena dropped while data keeps changing
        do_reset();
        ena = 1'b1;
        data_in = 8'h01; step(); tp = cyc;
        data_in = 8'h02; step();
        data_in = 8'h03; step();
        ena = 1'b0;
        for (int i = 0; i < 150; i++) begin
            data_in = 8'(i * 37);
            step();
        end
        check("s2_frames", rx_q.size(), 32'd3);
        if (rx_q.size() == 3) begin
            check("s2_byte0", {24'd0, rx_q[0]}, 32'h01);
            check("s2_byte1", {24'd0, rx_q[1]}, 32'h02);
            check("s2_byte2", {24'd0, rx_q[2]}, 32'h03);
            check("s2_latency", rx_t[0] - tp, 32'd1);
            check("s2_period01", rx_t[1] - rx_t[0], 32'd41);
            check("s2_period12", rx_t[2] - rx_t[1], 32'd41);
        end
        check("s2_peak_count", max_count, 32'd2);

        // Twelve distinct values back to back: 9 accepted, rest overflow
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_in = 8'h10 + 8'(i);
            step();
            check($sformatf("s3_count%0d", i), {27'd0, fifo_count}, (i == 0) ? 32'd1 : ((i > 8) ? 32'd8 : 32'(i)));
            check($sformatf("s3_ovf%0d", i), {31'd0, overflow}, (i >= 9) ? 32'd1 : 32'd0);
        end
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (rx_q.size() >= 9 && !busy && fifo_count == 5'd0) found = 1'b1;
        end
        check("s3_drained", {31'd0, found}, 32'd1);
        check("s3_frames", rx_q.size(), 32'd9);
        for (int i = 0; i < 9 && i < rx_q.size(); i++)
            check($sformatf("s3_byte%0d", i), {24'd0, rx_q[i]}, 32'h10 + 32'(i));
        check("s3_ovf_sticky", {31'd0, overflow}, 32'd1);

        // Push on the very edge the head is popped from a full FIFO
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 9; i++) begin
            data_in = 8'h20 + 8'(i);
            step();
        end
        check("s4_full", {27'd0, fifo_count}, 32'd8);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (!busy && fifo_count == 5'd8) found = 1'b1;
        end
        check("s4_idle_full", {31'd0, found}, 32'd1);
        data_in = 8'h30;
        step();
        check("s4_count", {27'd0, fifo_count}, 32'd8);
        check("s4_ovf", {31'd0, overflow}, 32'd0);
        check("s4_busy", {31'd0, busy}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            step();
            if (rx_q.size() >= 10 && !busy && fifo_count == 5'd0) found = 1'b1;
        end
        check("s4_frames", rx_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < rx_q.size(); i++)
            check($sformatf("s4_byte%0d", i), {24'd0, rx_q[i]}, (i < 9) ? 32'h20 + 32'(i) : 32'h30);

        // ena low while data toggles, then one capture of the current value
        do_reset();
        cnt_bad = 0;
        for (int i = 0; i < 100; i++) begin
            data_in = (i % 2 == 1) ? 8'hC3 : 8'h5A;
            step();
            if (fifo_count != 5'd0) cnt_bad++;
        end
        check("s5_tx_idle", tx_low_cycles, 32'd0);
        check("s5_no_push", cnt_bad, 32'd0);
        ena = 1'b1;
        repeat (60) step();
        check("s5_frames", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("s5_byte", {24'd0, rx_q[0]}, 32'hC3);

        // Reset mid-frame with three bytes queued
        do_reset();
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = 8'h40 + 8'(i);
            step();
        end
        check("s6_queued", {27'd0, fifo_count}, 32'd3);
        ena = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        step();
        check("s6_tx", {31'd0, tx}, 32'd1);
        check("s6_busy", {31'd0, busy}, 32'd0);
        check("s6_count", {27'd0, fifo_count}, 32'd0);
        check("s6_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        tx_low_cycles = 0;
        repeat (80) step();
        check("s6_quiet_tx", tx_low_cycles, 32'd0);
        check("s6_quiet_frames", rx_q.size(), 32'd0);
        ena = 1'b1; data_in = 8'h43;
        step();
        check("s6_recapture", {27'd0, fifo_count}, 32'd1);
        repeat (60) step();
        check("s6_frames", rx_q.size(), 32'd1);
        if (rx_q.size() == 1) check("s6_byte", {24'd0, rx_q[0]}, 32'h43);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
